// File: rtl/pc_redirect_unit_if.sv
// Bundle between the EX stage / hazard logic and the PC redirect unit.
// The pipeline side drives EX operands and reads fetch control back.
interface pc_redirect_unit_if #(
    parameter int CNT_W = 16
);
    logic              stall;
    logic              ex_valid;
    logic [1:0]        ex_ctrl_transfer;
    logic [2:0]        ex_funct3;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_imm;
    logic [31:0]       ex_rs1;
    logic [31:0]       ex_rs2;
    logic [31:0]       pc;
    logic [31:0]       pc_plus4;
    logic              flush;
    logic              halted;
    logic [31:0]       err_pc;
    logic [CNT_W-1:0]  branch_cnt;
    logic [CNT_W-1:0]  taken_cnt;

    modport master (
        output stall, ex_valid, ex_ctrl_transfer, ex_funct3,
               ex_pc, ex_imm, ex_rs1, ex_rs2,
        input  pc, pc_plus4, flush, halted, err_pc, branch_cnt, taken_cnt
    );

    modport slave (
        input  stall, ex_valid, ex_ctrl_transfer, ex_funct3,
               ex_pc, ex_imm, ex_rs1, ex_rs2,
        output pc, pc_plus4, flush, halted, err_pc, branch_cnt, taken_cnt
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// Program counter owner: resolves EX-stage branches/jumps, redirects fetch,
// flushes the two younger stages and halts on a misaligned target.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    pc_redirect_unit_if.slave bus
);
    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    localparam logic [1:0] CT_BR   = 2'b01;
    localparam logic [1:0] CT_JAL  = 2'b10;
    localparam logic [1:0] CT_JALR = 2'b11;

    state_t            r_state;
    logic [31:0]       r_pc;
    logic [31:0]       r_err_pc;
    logic              r_halted;
    logic [CNT_W-1:0]  r_branch_cnt;
    logic [CNT_W-1:0]  r_taken_cnt;

    logic              w_active;
    logic              w_is_br;
    logic              w_is_jump;
    logic              w_cond;
    logic [31:0]       w_br_tgt;
    logic [31:0]       w_jalr_sum;
    logic [31:0]       w_target;
    logic              w_take;
    logic              w_misaligned;
    logic              w_redirect;

    assign w_active  = bus.ex_valid && (r_state == S_RUN);
    assign w_is_br   = (bus.ex_ctrl_transfer == CT_BR);
    assign w_is_jump = (bus.ex_ctrl_transfer == CT_JAL) || (bus.ex_ctrl_transfer == CT_JALR);

    always_comb begin
        w_cond = 1'b0;
        case (bus.ex_funct3)
            3'b000:  w_cond = (bus.ex_rs1 == bus.ex_rs2);
            3'b001:  w_cond = (bus.ex_rs1 != bus.ex_rs2);
            3'b100:  w_cond = ($signed(bus.ex_rs1) <  $signed(bus.ex_rs2));
            3'b101:  w_cond = ($signed(bus.ex_rs1) >= $signed(bus.ex_rs2));
            3'b110:  w_cond = (bus.ex_rs1 <  bus.ex_rs2);
            3'b111:  w_cond = (bus.ex_rs1 >= bus.ex_rs2);
            default: w_cond = 1'b0;
        endcase
    end

    assign w_br_tgt   = bus.ex_pc + bus.ex_imm;
    assign w_jalr_sum = bus.ex_rs1 + bus.ex_imm;
    assign w_target   = (bus.ex_ctrl_transfer == CT_JALR) ? {w_jalr_sum[31:1], 1'b0} : w_br_tgt;

    assign w_take       = w_active && (w_is_jump || (w_is_br && w_cond));
    assign w_misaligned = w_take && w_target[1];
    assign w_redirect   = w_take && !w_target[1];

    // Misaligned targets flush too, so the bad path never reaches EX.
    assign bus.flush      = !reset && ((r_state == S_HALT) || w_take);
    assign bus.pc         = r_pc;
    assign bus.pc_plus4   = r_pc + 32'd4;
    assign bus.halted     = r_halted;
    assign bus.err_pc     = r_err_pc;
    assign bus.branch_cnt = r_branch_cnt;
    assign bus.taken_cnt  = r_taken_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_RUN;
            r_pc         <= RESET_PC;
            r_err_pc     <= 32'd0;
            r_halted     <= 1'b0;
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (w_active && w_is_br && (r_branch_cnt != '1))
                        r_branch_cnt <= r_branch_cnt + 1'b1;
                    if (w_misaligned) begin
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                        r_err_pc <= bus.ex_pc;
                    end else if (w_redirect) begin
                        r_pc <= w_target;
                        if (r_taken_cnt != '1)
                            r_taken_cnt <= r_taken_cnt + 1'b1;
                    end else if (!bus.stall) begin
                        r_pc <= r_pc + 32'd4;
                    end
                end
                S_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed + random stimulus on two instances (16-bit and 2-bit counters)
// compared against a cycle-level behavioural model of the PC redirect rules.
module tb_pc_redirect_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset, stall, ex_valid;
    logic [1:0]  ex_ctrl;
    logic [2:0]  ex_f3;
    logic [31:0] ex_pc, ex_imm, ex_rs1, ex_rs2;

    int total = 0;
    int bad   = 0;

    // model state
    bit          m_init = 0;
    bit          m_halt;
    logic [31:0] m_pc, m_err;
    int          m_bc, m_tc;

    always #5 clk = ~clk;

    pc_redirect_unit_if #(.CNT_W(16)) ifa ();
    pc_redirect_unit_if #(.CNT_W(2))  ifb ();

    assign ifa.stall = stall;           assign ifb.stall = stall;
    assign ifa.ex_valid = ex_valid;     assign ifb.ex_valid = ex_valid;
    assign ifa.ex_ctrl_transfer = ex_ctrl; assign ifb.ex_ctrl_transfer = ex_ctrl;
    assign ifa.ex_funct3 = ex_f3;       assign ifb.ex_funct3 = ex_f3;
    assign ifa.ex_pc = ex_pc;           assign ifb.ex_pc = ex_pc;
    assign ifa.ex_imm = ex_imm;         assign ifb.ex_imm = ex_imm;
    assign ifa.ex_rs1 = ex_rs1;         assign ifb.ex_rs1 = ex_rs1;
    assign ifa.ex_rs2 = ex_rs2;         assign ifb.ex_rs2 = ex_rs2;

    pc_redirect_unit #(.RESET_PC(RPC), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(ifa));
    pc_redirect_unit #(.RESET_PC(RPC), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .bus(ifb));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit cond_true(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a; sb = b;
        case (f)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return a < b;
            3'd7: return a >= b;
            default: return 0;
        endcase
    endfunction

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    // One EX cycle: drive, check pre-edge outputs, advance model at the edge.
    task automatic step(input bit rst, input bit st, input bit v, input logic [1:0] c,
                        input logic [2:0] f, input logic [31:0] p, input logic [31:0] i,
                        input logic [31:0] a, input logic [31:0] b);
        bit          take;
        logic [31:0] tgt;
        reset = rst; stall = st; ex_valid = v; ex_ctrl = c; ex_f3 = f;
        ex_pc = p; ex_imm = i; ex_rs1 = a; ex_rs2 = b;
        #1;
        tgt  = (c == 2'd3) ? ((a + i) & 32'hFFFF_FFFE) : (p + i);
        take = m_init && !m_halt && v && (c == 2'd2 || c == 2'd3 || (c == 2'd1 && cond_true(f, a, b)));
        chk("flush",   {31'd0, ifa.flush}, {31'd0, !rst && m_init && (m_halt || take)});
        chk("flush_s", {31'd0, ifb.flush}, {31'd0, !rst && m_init && (m_halt || take)});
        if (m_init) begin
            chk("pc",        ifa.pc,       m_pc);
            chk("pc_s",      ifb.pc,       m_pc);
            chk("pc_plus4",  ifa.pc_plus4, m_pc + 32'd4);
            chk("halted",    {31'd0, ifa.halted}, {31'd0, m_halt});
            chk("halted_s",  {31'd0, ifb.halted}, {31'd0, m_halt});
            chk("err_pc",    ifa.err_pc,   m_err);
            chk("branch_cnt",   {16'd0, ifa.branch_cnt}, sat(m_bc, 16));
            chk("taken_cnt",    {16'd0, ifa.taken_cnt},  sat(m_tc, 16));
            chk("branch_cnt_s", {30'd0, ifb.branch_cnt}, sat(m_bc, 2));
            chk("taken_cnt_s",  {30'd0, ifb.taken_cnt},  sat(m_tc, 2));
        end
        @(posedge clk);
        if (rst) begin
            m_init = 1; m_halt = 0; m_pc = RPC; m_err = 0; m_bc = 0; m_tc = 0;
        end else if (m_init && !m_halt) begin
            if (v && c == 2'd1) m_bc++;
            if (take && tgt[1]) begin
                m_halt = 1; m_err = p;
            end else if (take) begin
                m_pc = tgt; m_tc++;
            end else if (!st) begin
                m_pc = m_pc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] rp, ri, ra, rb;
        @(negedge clk);
        // reset, then free-running fetch from RESET_PC
        step(1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 2, 0, 0, 8, 0, 0);
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pc_after_3", ifa.pc, 32'h10C);
        // signed-lt taken, then unsigned-lt not taken with same operands
        step(0, 0, 1, 1, 3'b100, 32'h40, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1);
        chk("blt_target", ifa.pc, 32'h30);
        step(0, 0, 1, 1, 3'b110, 32'h40, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1);
        chk("bltu_seq", ifa.pc, 32'h34);
        // misaligned JALR under stall, then frozen HALT
        step(0, 1, 1, 3, 0, 32'h60, 32'd2, 32'h201, 0);
        chk("halt_err_pc", ifa.err_pc, 32'h60);
        for (int k = 0; k < 5; k++) step(0, k[0], 1, 2, 0, 32'h70, 32'h20, 0, 0);
        chk("halt_frozen_pc", ifa.pc, 32'h34);
        step(1, 0, 1, 3, 0, 32'h60, 32'd2, 32'h201, 0);
        // JAL beats stall, then stall holds
        step(0, 1, 1, 2, 0, 32'h80, 32'h10, 0, 0);
        chk("jal_over_stall", ifa.pc, 32'h90);
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        // bubble with a JAL code is ignored
        step(0, 0, 0, 2, 0, 32'h80, 32'h400, 0, 0);
        for (int k = 0; k < 5; k++) step(0, 0, 1, 1, 3'b000, 32'h200, 32'd8, 32'h5, 32'h5);
        chk("taken_sat2", {30'd0, ifb.taken_cnt}, 32'd3);
        // sequential wrap past the top of the address space
        step(0, 0, 1, 2, 0, 32'h0, 32'hFFFF_FFFC, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pc_wrap", ifa.pc, 32'h0);
        // random traffic
        for (int n = 0; n < 600; n++) begin
            rp = $urandom & 32'hFFFF_FFFC;
            ri = ($urandom_range(0, 64) - 32) * 4;
            if ($urandom_range(0, 9) == 0) ri = ri + 32'd2;
            ra = $urandom;
            if ($urandom_range(0, 3) == 0) ra = ra & 32'hFFFF_FFFC;
            rb = ($urandom_range(0, 2) == 0) ? ra : $urandom;
            step((m_halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), rp, ri, ra, rb);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
